// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with burst hold feeding a one-entry registered ready/valid output.
// Optional per-requester saturating grant counters: define FIFO_RR_ARBITER_GRANT_CTR_EN.
module fifo_rr_arbiter #(
  parameter int N_REQS     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 1,
  localparam int SRC_WIDTH   = $clog2(N_REQS),
  localparam int BURST_WIDTH = $clog2(BURST_LEN + 1)
) (
  input  logic                                clk,
  input  logic                                rst_aH,
  input  logic [N_REQS-1:0]                   req_valid,
  input  logic [N_REQS-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [N_REQS-1:0]                   req_ready,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [SRC_WIDTH-1:0]                out_src,
  input  logic                                out_ready
`ifdef FIFO_RR_ARBITER_GRANT_CTR_EN
  ,
  input  logic                                grant_cnt_clr,
  output logic [N_REQS-1:0][15:0]             grant_cnt
`endif
);

  logic [SRC_WIDTH-1:0]   ptr, owner, win, idx;
  logic [SRC_WIDTH-1:0]   ptr_nxt, owner_nxt;
  logic [BURST_WIDTH-1:0] burst_cnt, cnt_nxt;
  logic                   has_win, hold, slot_free, xfer;

  function automatic logic [SRC_WIDTH-1:0] next_idx(input logic [SRC_WIDTH-1:0] x);
    return (int'(x) == N_REQS - 1) ? '0 : x + SRC_WIDTH'(1);
  endfunction

  assign slot_free = ~out_valid | out_ready;

  always_comb begin
    hold    = (burst_cnt != '0) && (int'(burst_cnt) < BURST_LEN) && req_valid[owner];
    win     = '0;
    idx     = '0;
    has_win = 1'b0;
    if (hold) begin
      win     = owner;
      has_win = 1'b1;
    end else begin
      for (int k = 0; k < N_REQS; k++) begin
        idx = SRC_WIDTH'((int'(ptr) + k) % N_REQS);
        if (!has_win && req_valid[idx]) begin
          win     = idx;
          has_win = 1'b1;
        end
      end
    end
  end

  assign xfer      = has_win & slot_free & ~rst_aH;
  assign req_ready = xfer ? (N_REQS'(1) << win) : '0;

  // A transfer from another requester starts a fresh burst; the break still rotates ptr past the old owner.
  always_comb begin
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    if ((burst_cnt != '0) && !(xfer && (win == owner))) begin
      ptr_nxt = next_idx(owner);
      cnt_nxt = '0;
    end
    if (xfer) begin
      if ((win == owner) && (burst_cnt != '0)) begin
        cnt_nxt = burst_cnt + BURST_WIDTH'(1);
      end else begin
        owner_nxt = win;
        cnt_nxt   = BURST_WIDTH'(1);
      end
      if (int'(cnt_nxt) == BURST_LEN) begin
        ptr_nxt = next_idx(win);
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (slot_free) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= req_data[win];
        out_src   <= win;
      end else begin
        out_valid <= 1'b0;
      end
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

`ifdef FIFO_RR_ARBITER_GRANT_CTR_EN
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      grant_cnt <= '0;
    end else if (grant_cnt_clr) begin
      grant_cnt <= '0;
    end else if (xfer && (grant_cnt[win] != 16'hFFFF)) begin
      grant_cnt[win] <= grant_cnt[win] + 16'd1;
    end
  end
`endif

endmodule
